// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle control FSM and the datapath.
// The FSM takes the master modport; the datapath (or a bench) takes the slave modport.
interface mc_control_if #(
  parameter int IOP_W = 4
);
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             ir_write;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             lui_sel;
  logic             link_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [IOP_W-1:0] i_op;
  logic [1:0]       pc_src;
  logic [1:0]       fault;
  logic             busy;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, lui_sel, link_write, alu_src_a, alu_src_b, alu_op,
           i_op, pc_src, fault, busy
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, lui_sel, link_write, alu_src_a, alu_src_b, alu_op,
           i_op, pc_src, fault, busy
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset control FSM: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables, and latches sticky illegal-opcode / memory-timeout faults.
module mc_control_fsm #(
  parameter int               MEM_WAIT_MAX = 15,
  parameter int               HAS_JAL      = 1,
  parameter int               IOP_W        = 4,
  parameter logic [IOP_W-1:0] IOP_ADD      = 4'd2,
  parameter logic [IOP_W-1:0] IOP_AND      = 4'd0,
  parameter logic [IOP_W-1:0] IOP_OR       = 4'd1,
  parameter logic [IOP_W-1:0] IOP_SLT      = 4'd7
) (
  input  logic          clk,
  input  logic          rst,
  mc_control_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB,
    BRANCH, I_EXEC, I_WB, LUI_WB, JUMP, FAULT
  } state_t;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic [5:0] op_q_reg, op_q_next;
  logic [1:0] fault_reg, fault_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= FETCH;
      wait_cnt_reg <= 8'd0;
      op_q_reg     <= 6'd0;
      fault_reg    <= 2'b00;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      op_q_reg     <= op_q_next;
      fault_reg    <= fault_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    op_q_next      = op_q_reg;
    fault_next     = fault_reg;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.lui_sel    = 1'b0;
    bus.link_write = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.i_op       = '0;
    bus.pc_src     = 2'b00;
    bus.fault      = fault_reg;
    bus.busy       = (state_reg != FAULT);

    // Shared wait handling for the three memory states; mem_ready beats the timeout.
    if (state_reg == FETCH || state_reg == MEM_RD || state_reg == MEM_WR) begin
      if (bus.mem_ready) begin
        wait_cnt_next = 8'd0;
      end else if (wait_cnt_reg == WAIT_MAX) begin
        wait_cnt_next = 8'd0;
        state_next    = FAULT;
        fault_next    = 2'b10;
      end else begin
        wait_cnt_next = wait_cnt_reg + 8'd1;
      end
    end

    case (state_reg)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_next = DECODE;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        op_q_next     = bus.opcode;
        case (bus.opcode)
          6'd35, 6'd43:                        state_next = MEM_ADDR;
          6'd0:                                state_next = R_EXEC;
          6'd4, 6'd5:                          state_next = BRANCH;
          6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13: state_next = I_EXEC;
          6'd15:                               state_next = LUI_WB;
          6'd2:                                state_next = JUMP;
          6'd3: begin
            if (HAS_JAL != 0) begin
              state_next = JUMP;
            end else begin
              state_next = FAULT;
              fault_next = 2'b01;
            end
          end
          default: begin
            state_next = FAULT;
            fault_next = 2'b01;
          end
        endcase
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_next    = (op_q_reg == 6'd35) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) state_next = MEM_WB;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_next     = FETCH;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        if (bus.mem_ready) state_next = FETCH;
      end
      R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_next    = R_WB;
      end
      R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        state_next    = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b01;
        bus.pc_src    = 2'b01;
        bus.pc_write  = ((op_q_reg == 6'd4) && bus.zero) ||
                        ((op_q_reg == 6'd5) && !bus.zero);
        state_next    = FETCH;
      end
      I_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 2'b11;
        case (op_q_reg)
          6'd8, 6'd9:   bus.i_op = IOP_ADD;
          6'd10, 6'd11: bus.i_op = IOP_SLT;
          6'd12:        bus.i_op = IOP_AND;
          6'd13:        bus.i_op = IOP_OR;
          default:      bus.i_op = '0;
        endcase
        state_next = I_WB;
      end
      I_WB: begin
        bus.reg_write = 1'b1;
        state_next    = FETCH;
      end
      LUI_WB: begin
        bus.reg_write = 1'b1;
        bus.lui_sel   = 1'b1;
        state_next    = FETCH;
      end
      JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'b10;
        if (op_q_reg == 6'd3) begin
          bus.reg_write  = 1'b1;
          bus.link_write = 1'b1;
        end
        state_next = FETCH;
      end
      default: begin
        state_next = FAULT;
      end
    endcase

    // Reset holds every output low regardless of the (possibly unknown) state.
    if (!rst) begin
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.iord       = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.lui_sel    = 1'b0;
      bus.link_write = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.alu_op     = 2'b00;
      bus.i_op       = '0;
      bus.pc_src     = 2'b00;
      bus.fault      = 2'b00;
      bus.busy       = 1'b0;
    end
  end

endmodule
